// File: rtl/fir_mac_sequencer.sv
// Sequential FIR filter: one shared external multiplier, one tap per cycle.
// A sample is shifted into the delay line, Taps products are accumulated with
// symmetric saturation, and the result is presented with a one-cycle strobe.
module fir_mac_sequencer #(
    parameter int unsigned Width     = 25,
    parameter int unsigned Presicion = 16,
    parameter int unsigned Taps      = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [Width-1:0]       sample_in,
    input  logic                          sample_valid,
    input  logic                          coef_we,
    input  logic [$clog2(Taps)-1:0]       coef_addr,
    input  logic signed [Width-1:0]       coef_data,
    output logic signed [Width-1:0]       mul_a,
    output logic signed [Width-1:0]       mul_b,
    input  logic signed [Width-1:0]       mul_y,
    output logic signed [Width-1:0]       y_out,
    output logic                          y_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned AW = $clog2(Taps);
    localparam logic [AW-1:0] LAST_K = AW'(Taps - 1);
    localparam logic [AW:0] TAPS_W = (AW + 1)'(Taps);
    localparam logic signed [Width:0] MAX_EXT = (Width + 1)'((64'(1) << (Width - 1)) - 64'(1));
    localparam logic signed [Width:0] MIN_EXT = -MAX_EXT;
    localparam logic signed [Width-1:0] MAX_W = MAX_EXT[Width-1:0];
    localparam logic signed [Width-1:0] MIN_W = MIN_EXT[Width-1:0];

    // Reject parameter sets the datapath is not built for
    if (Taps < 2 || Taps > 16 || Presicion >= Width) begin : g_param_check
        $error("fir_mac_sequencer: unsupported Width/Presicion/Taps combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [Width-1:0] sample_q;
    logic signed [Width-1:0] x_q [Taps];
    logic signed [Width-1:0] c_q [Taps];
    logic signed [Width-1:0] acc_q;
    logic [AW-1:0]           k_q;
    logic signed [Width-1:0] y_out_q;
    logic                    y_valid_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic signed [Width:0]   sum_c;
    logic signed [Width-1:0] acc_sat_c;
    logic                    coef_wr_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_valid) state_d = SHIFT;
            SHIFT:   state_d = MAC;
            MAC:     if (k_q == LAST_K) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier operands: only the current tap during MAC, zero otherwise
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == MAC) begin
            mul_a = x_q[k_q];
            mul_b = c_q[k_q];
        end
    end

    // Accumulate with one guard bit and clamp to the symmetric range
    always_comb begin
        sum_c = $signed({acc_q[Width-1], acc_q}) + $signed({mul_y[Width-1], mul_y});
        if (sum_c > MAX_EXT) begin
            acc_sat_c = MAX_W;
        end else if (sum_c < MIN_EXT) begin
            acc_sat_c = MIN_W;
        end else begin
            acc_sat_c = sum_c[Width-1:0];
        end
    end

    // Delay line shifts only in SHIFT, so dropped samples never touch it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Taps; i++) x_q[i] <= '0;
        end else if (state_q == SHIFT) begin
            x_q[0] <= sample_q;
            for (int i = 1; i < Taps; i++) x_q[i] <= x_q[i-1];
        end
    end

    // Coefficients are writable only while idle and with an in-range address
    assign coef_wr_c = (state_q == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_W);

    // Coefficient bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Taps; i++) c_q[i] <= '0;
        end else if (coef_wr_c) begin
            c_q[coef_addr] <= coef_data;
        end
    end

    // Sample capture, accumulator and tap index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= '0;
            acc_q    <= '0;
            k_q      <= '0;
        end else begin
            case (state_q)
                IDLE:    if (sample_valid) sample_q <= sample_in;
                SHIFT: begin
                    acc_q <= '0;
                    k_q   <= '0;
                end
                MAC: begin
                    acc_q <= acc_sat_c;
                    k_q   <= k_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered result, strobe, busy and sticky overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            y_valid_q <= (state_q == DONE);
            busy_q    <= (state_d != IDLE);
            if (state_q == DONE) y_out_q <= acc_q;
            if (sample_valid && state_q != IDLE) overrun_q <= 1'b1;
        end
    end

    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
